pll_lock_sequencer: RTL and testbench
=====================================

Name: pll_lock_sequencer

Overview:
- Consumer end of the PLL interface: drives the PLL reset input and watches the PLL's lock output.
- Runs in the PLL reference clock domain (50 MHz refclk).
- Releases the system reset only after lock has been stable for a qualified period.
- Re-sequences the PLL on lock timeout or loss of lock, and reports retries, lock losses and permanent failure.

Parameters:
- RST_CYCLES, 16: cycles pll_rst is held high per PLL reset attempt (≥1).
- LOCK_TIMEOUT, 50000: cycles to wait for synchronized lock before retrying (1 ms at 50 MHz).
- STABLE_CYCLES, 1024: consecutive synchronized-lock cycles required before system reset release.
- MAX_RETRIES, 7: lock timeouts tolerated before FAIL.
- SYNC_STAGES, 2: synchronizer depth for pll_locked (≥2).

Ports:
- refclk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- pll_locked  in  1  PLL lock output, asynchronous to refclk.
- pll_rst  out  1  active-high reset to the PLL.
- sys_rst  out  1  active-high system reset for logic clocked by the PLL outputs.
- ready  out  1  high only in RUN.
- fail  out  1  high only in FAIL.
- retry_cnt  out  $clog2(MAX_RETRIES+1)  lock timeouts since last RUN entry.
- lost_cnt  out  8  saturating count of lock losses while in RUN.
- state  out  3  current state encoding, for debug.

Behaviour:
- Clocking and reset:
  - One clock, refclk. Reset is synchronous and active-high on rst.
  - Reset values: state=PLL_RESET, pll_rst=1, sys_rst=1, ready=0, fail=0, retry_cnt=0, lost_cnt=0, timer=0, synchronizer flops=0.
  - rst asserted in any state returns all of the above on the next edge. lost_cnt is also cleared.
- Synchronizer:
  - pll_locked passes through SYNC_STAGES flops to give lk.
  - All decisions use lk. Input-to-decision latency is SYNC_STAGES cycles.
- Outputs: all registered, no combinational paths from inputs.
- One shared timer, width $clog2(max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)+1). It clears on every state transition.
- State encodings: PLL_RESET=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAIL=4.
- PLL_RESET:
  - pll_rst=1, sys_rst=1.
  - Exactly RST_CYCLES cycles, then WAIT_LOCK.
- WAIT_LOCK:
  - pll_rst=0, sys_rst=1.
  - lk=1 → STABLE.
  - Timer reaches LOCK_TIMEOUT-1 with lk=0 → timeout:
    - if retry_cnt==MAX_RETRIES → FAIL;
    - else retry_cnt+1 and go to PLL_RESET.
  - lk rising on the same cycle as the timeout: lock wins, go to STABLE.
- STABLE:
  - pll_rst=0, sys_rst=1.
  - lk=0 → WAIT_LOCK. The timer restarts and there is no retry increment.
  - lk=1 for STABLE_CYCLES consecutive cycles → RUN.
- RUN:
  - pll_rst=0, sys_rst=0, ready=1.
  - retry_cnt clears on entry.
  - lk=0 → PLL_RESET. On the same edge: sys_rst=1, ready=0, lost_cnt+1 (saturates at 255).
  - sys_rst therefore rises SYNC_STAGES+1 edges after pll_locked falls.
- FAIL:
  - pll_rst=1, sys_rst=1, fail=1.
  - Terminal; exited only by rst.
- Glitch handling:
  - A single-cycle lk low in STABLE restarts qualification.
  - A single-cycle lk low in RUN triggers a full re-sequence.
  - No filtering is applied in RUN by design.

Decomposition:
- Package pll_seq_pkg holds:
  - the state enum and its encodings above;
  - the lost_cnt width constant (8);
  - a function returning the timer width from the three timing parameters.
- One sub-module, sync_bit: a parameterized SYNC_STAGES-deep single-bit synchronizer with synchronous reset to 0. It is reused by the other cross-domain blocks.

Test Plan (RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2, SYNC_STAGES=2):
- Nominal lock:
  - Stimulus: release rst; raise pll_locked 10 cycles after pll_rst falls.
  - Response: pll_rst high exactly 4 cycles. sys_rst falls and ready rises 2+8 cycles after pll_locked rises (±1 for entry edge, checked exactly by scoreboard). retry_cnt=0.
- Timeout retry:
  - Stimulus: hold pll_locked=0.
  - Response: after 4+20 cycles pll_rst pulses again and retry_cnt=1. A second timeout gives retry_cnt=2. The third timeout enters FAIL with fail=1, pll_rst=1, sys_rst=1, and these hold for 100 further cycles.
- Stable glitch:
  - Stimulus: in STABLE, drop pll_locked for 1 cycle at qualification cycle 5.
  - Response: state goes to WAIT_LOCK, then STABLE again. ready is delayed by the full 8 cycles after re-lock. retry_cnt unchanged.
- Loss in RUN:
  - Stimulus: in RUN, drop pll_locked.
  - Response: sys_rst=1 and ready=0 exactly 3 edges later. lost_cnt=1. pll_rst high 4 cycles. Re-lock returns to RUN with retry_cnt=0.
- Saturation and reset mid-operation:
  - Stimulus: force 260 RUN losses, then assert rst during STABLE.
  - Response: lost_cnt stops at 255. The next edge after rst gives state=0, pll_rst=1, sys_rst=1, lost_cnt=0.
- Timeout/lock tie:
  - Stimulus: lk rises on the timer's last WAIT_LOCK cycle.
  - Response: enters STABLE with no retry increment.

Source files
------------

// File: rtl/pll_seq_pkg.sv
// Shared types and sizing helpers for the PLL lock sequencer.
// State encodings are visible on the debug port, so they are fixed here.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    PLL_RESET = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } seq_state_t;

  localparam int LOST_W = 8;

  // The single shared timer must hold the largest of the three phase lengths.
  function automatic int timer_width(input int rst_cycles, input int lock_timeout,
                                     input int stable_cycles);
    int longest;
    longest = rst_cycles;
    if (lock_timeout > longest) longest = lock_timeout;
    if (stable_cycles > longest) longest = stable_cycles;
    return $clog2(longest + 1);
  endfunction

endpackage

// File: rtl/sync_bit.sv
// Single-bit multi-flop synchronizer with synchronous reset to 0.
// STAGES must be at least 2.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] flops;

  always_ff @(posedge clk) begin
    if (rst) flops <= '0;
    else     flops <= {flops[STAGES-2:0], d};
  end

  assign q = flops[STAGES-1];

endmodule

// File: rtl/pll_lock_sequencer.sv
// Drives the PLL reset, qualifies its lock output, and releases the system
// reset only after lock has been continuously stable; re-sequences on loss.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 7,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                               refclk,
  input  logic                               rst,
  input  logic                               pll_locked,
  output logic                               pll_rst,
  output logic                               sys_rst,
  output logic                               ready,
  output logic                               fail,
  output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_cnt,
  output logic [LOST_W-1:0]                  lost_cnt,
  output logic [2:0]                         state
);

  localparam int RETRY_W = $clog2(MAX_RETRIES + 1);
  localparam int TMR_W   = timer_width(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);

  localparam logic [TMR_W-1:0]   RST_LAST = TMR_W'(RST_CYCLES - 1);
  localparam logic [TMR_W-1:0]   TMO_LAST = TMR_W'(LOCK_TIMEOUT - 1);
  localparam logic [TMR_W-1:0]   STB_LAST = TMR_W'(STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

  seq_state_t       cur_state, next_state;
  logic [TMR_W-1:0] timer;
  logic             lk;

  sync_bit #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d   (pll_locked),
    .q   (lk)
  );

  // NOTE: every variable in an always_comb gets a default first so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = cur_state;
    unique case (cur_state)
      PLL_RESET: if (timer == RST_LAST) next_state = WAIT_LOCK;
      // Lock is tested before the timeout so a same-cycle tie goes to STABLE.
      WAIT_LOCK: begin
        if (lk)                    next_state = STABLE;
        else if (timer == TMO_LAST) next_state = (retry_cnt == RETRY_MAX) ? FAIL : PLL_RESET;
      end
      STABLE: begin
        if (!lk)                   next_state = WAIT_LOCK;
        else if (timer == STB_LAST) next_state = RUN;
      end
      RUN:       if (!lk) next_state = PLL_RESET;
      FAIL:      next_state = FAIL;
      default:   next_state = PLL_RESET;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge refclk) begin
    if (rst) begin
      cur_state <= PLL_RESET;
      timer     <= '0;
      retry_cnt <= '0;
      lost_cnt  <= '0;
      pll_rst   <= 1'b1;
      sys_rst   <= 1'b1;
      ready     <= 1'b0;
      fail      <= 1'b0;
    end else begin
      cur_state <= next_state;

      if (next_state != cur_state)
        timer <= '0;
      else if (cur_state inside {PLL_RESET, WAIT_LOCK, STABLE})
        timer <= timer + TMR_W'(1);

      if (cur_state == WAIT_LOCK && next_state == PLL_RESET)
        retry_cnt <= retry_cnt + RETRY_W'(1);
      else if (cur_state != RUN && next_state == RUN)
        retry_cnt <= '0;

      if (cur_state == RUN && next_state == PLL_RESET && lost_cnt != '1)
        lost_cnt <= lost_cnt + LOST_W'(1);

      // Outputs follow the state being entered, so they change on the same edge.
      pll_rst <= (next_state == PLL_RESET) || (next_state == FAIL);
      sys_rst <= (next_state != RUN);
      ready   <= (next_state == RUN);
      fail    <= (next_state == FAIL);
    end
  end

  assign state = cur_state;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Self-checking bench for pll_lock_sequencer: fixed vector table, corner-case
// sequences and randomized lock activity, all against a cycle reference model.
module tb_pll_lock_sequencer;

  localparam int RST_CYCLES    = 4;
  localparam int LOCK_TIMEOUT  = 20;
  localparam int STABLE_CYCLES = 8;
  localparam int MAX_RETRIES   = 2;
  localparam int SYNC_STAGES   = 2;

  localparam int S_RESET = 0, S_WAIT = 1, S_STABLE = 2, S_RUN = 3, S_FAIL = 4;

  logic       refclk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
  logic       pll_rst, sys_rst, ready, fail;
  logic [1:0] retry_cnt;
  logic [7:0] lost_cnt;
  logic [2:0] state;

  int vectors = 0;
  int miscompares = 0;

  always #10 refclk = ~refclk;

  pll_lock_sequencer #(
    .RST_CYCLES    (RST_CYCLES),
    .LOCK_TIMEOUT  (LOCK_TIMEOUT),
    .STABLE_CYCLES (STABLE_CYCLES),
    .MAX_RETRIES   (MAX_RETRIES),
    .SYNC_STAGES   (SYNC_STAGES)
  ) dut (
    .refclk     (refclk),
    .rst        (rst),
    .pll_locked (pll_locked),
    .pll_rst    (pll_rst),
    .sys_rst    (sys_rst),
    .ready      (ready),
    .fail       (fail),
    .retry_cnt  (retry_cnt),
    .lost_cnt   (lost_cnt),
    .state      (state)
  );

  // Reference model: phase, dwell time in phase, retries, losses, and a queue
  // holding the last SYNC_STAGES lock samples (index SYNC_STAGES-1 is oldest).
  int m_phase = S_RESET;
  int m_dwell = 0;
  int m_retries = 0;
  int m_lost = 0;
  bit lk_pipe[$];

  task automatic clear_pipe();
    lk_pipe.delete();
    for (int i = 0; i < SYNC_STAGES; i++) lk_pipe.push_back(1'b0);
  endtask

  task automatic enter(input int phase);
    m_phase = phase;
    m_dwell = 0;
  endtask

  task automatic model_step();
    bit lk;
    if (rst) begin
      clear_pipe();
      m_retries = 0;
      m_lost    = 0;
      enter(S_RESET);
      return;
    end
    lk = lk_pipe[SYNC_STAGES-1];
    lk_pipe.push_front(pll_locked);
    void'(lk_pipe.pop_back());
    m_dwell++;
    case (m_phase)
      S_RESET: if (m_dwell == RST_CYCLES) enter(S_WAIT);
      S_WAIT: begin
        if (lk) enter(S_STABLE);
        else if (m_dwell == LOCK_TIMEOUT) begin
          if (m_retries == MAX_RETRIES) enter(S_FAIL);
          else begin m_retries++; enter(S_RESET); end
        end
      end
      S_STABLE: begin
        if (!lk) enter(S_WAIT);
        else if (m_dwell == STABLE_CYCLES) begin m_retries = 0; enter(S_RUN); end
      end
      S_RUN: if (!lk) begin
        if (m_lost < 255) m_lost++;
        enter(S_RESET);
      end
      default: ;
    endcase
  endtask

  task automatic compare_model();
    bit e_prst, e_srst, e_rdy, e_fl;
    e_prst = (m_phase == S_RESET) || (m_phase == S_FAIL);
    e_srst = (m_phase != S_RUN);
    e_rdy  = (m_phase == S_RUN);
    e_fl   = (m_phase == S_FAIL);
    vectors++;
    if (state !== 3'(m_phase) || pll_rst !== e_prst || sys_rst !== e_srst ||
        ready !== e_rdy || fail !== e_fl || retry_cnt !== 2'(m_retries) ||
        lost_cnt !== 8'(m_lost)) begin
      miscompares++;
      $display("FAIL model @%0t st/prst/srst/rdy/fail/retry/lost got %0d/%0b/%0b/%0b/%0b/%0d/%0d want %0d/%0b/%0b/%0b/%0b/%0d/%0d",
               $time, state, pll_rst, sys_rst, ready, fail, retry_cnt, lost_cnt,
               m_phase, e_prst, e_srst, e_rdy, e_fl, m_retries, m_lost);
    end
  endtask

  task automatic tick();
    @(posedge refclk);
    model_step();
    @(negedge refclk);
    compare_model();
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic wait_model(input int phase, input int budget, input string name);
    int n;
    n = 0;
    while (m_phase != phase && n < budget) begin
      tick();
      n++;
    end
    vectors++;
    if (m_phase != phase) begin
      miscompares++;
      $display("FAIL %s: phase %0d not reached in %0d cycles (at %0d)", name, phase, budget, m_phase);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pll_locked = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  typedef struct {
    bit rst;
    bit lock;
    int n;
    int st;
    bit prst;
    bit srst;
    bit rdy;
    bit fl;
    int rc;
    int lc;
  } vec_t;

  vec_t tbl[$];

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    clear_pipe();

    // Timeouts into FAIL, then nominal lock and one loss in RUN.
    //              rst lk   n   st prst srst rdy fl rc lc
    tbl.push_back('{1, 0,   2,  0, 1,   1,   0,  0, 0, 0});
    tbl.push_back('{0, 0,   3,  0, 1,   1,   0,  0, 0, 0});
    tbl.push_back('{0, 0,   1,  1, 0,   1,   0,  0, 0, 0});
    tbl.push_back('{0, 0,  19,  1, 0,   1,   0,  0, 0, 0});
    tbl.push_back('{0, 0,   1,  0, 1,   1,   0,  0, 1, 0});
    tbl.push_back('{0, 0,  24,  0, 1,   1,   0,  0, 2, 0});
    tbl.push_back('{0, 0,  24,  4, 1,   1,   0,  1, 2, 0});
    tbl.push_back('{0, 0, 100,  4, 1,   1,   0,  1, 2, 0});
    tbl.push_back('{1, 0,   2,  0, 1,   1,   0,  0, 0, 0});
    tbl.push_back('{0, 0,  14,  1, 0,   1,   0,  0, 0, 0});
    tbl.push_back('{0, 1,   2,  1, 0,   1,   0,  0, 0, 0});
    tbl.push_back('{0, 1,   1,  2, 0,   1,   0,  0, 0, 0});
    tbl.push_back('{0, 1,   7,  2, 0,   1,   0,  0, 0, 0});
    tbl.push_back('{0, 1,   1,  3, 0,   0,   1,  0, 0, 0});
    tbl.push_back('{0, 0,   2,  3, 0,   0,   1,  0, 0, 0});
    tbl.push_back('{0, 0,   1,  0, 1,   1,   0,  0, 0, 1});
    tbl.push_back('{0, 0,   3,  0, 1,   1,   0,  0, 0, 1});
    tbl.push_back('{0, 0,   1,  1, 0,   1,   0,  0, 0, 1});
    tbl.push_back('{0, 1,   2,  1, 0,   1,   0,  0, 0, 1});
    tbl.push_back('{0, 1,   1,  2, 0,   1,   0,  0, 0, 1});
    tbl.push_back('{0, 1,   8,  3, 0,   0,   1,  0, 0, 1});

    foreach (tbl[i]) begin
      rst = tbl[i].rst;
      pll_locked = tbl[i].lock;
      repeat (tbl[i].n) tick();
      check($sformatf("vec%0d state", i),   state,     tbl[i].st);
      check($sformatf("vec%0d pll_rst", i), pll_rst,   tbl[i].prst);
      check($sformatf("vec%0d sys_rst", i), sys_rst,   tbl[i].srst);
      check($sformatf("vec%0d ready", i),   ready,     tbl[i].rdy);
      check($sformatf("vec%0d fail", i),    fail,      tbl[i].fl);
      check($sformatf("vec%0d retry", i),   retry_cnt, tbl[i].rc);
      check($sformatf("vec%0d lost", i),    lost_cnt,  tbl[i].lc);
    end

    // One-cycle lock drop during qualification, after one earlier timeout.
    do_reset();
    wait_model(S_WAIT, 20, "glitch first wait");
    wait_model(S_RESET, 40, "glitch timeout");
    wait_model(S_WAIT, 20, "glitch second wait");
    pll_locked = 1'b1;
    wait_model(S_STABLE, 20, "glitch stable");
    check("glitch entry retry", retry_cnt, 1);
    repeat (4) tick();
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    tick();
    check("glitch S6 state", state, S_STABLE);
    tick();
    check("glitch S7 state", state, S_WAIT);
    tick();
    check("glitch S8 state", state, S_STABLE);
    check("glitch S8 retry", retry_cnt, 1);
    repeat (7) tick();
    check("glitch S15 state", state, S_STABLE);
    check("glitch S15 ready", ready, 0);
    tick();
    check("glitch S16 state", state, S_RUN);
    check("glitch S16 ready", ready, 1);
    check("glitch S16 sys_rst", sys_rst, 0);
    check("glitch S16 retry", retry_cnt, 0);

    // Lock becomes visible on the final WAIT_LOCK cycle.
    do_reset();
    wait_model(S_WAIT, 20, "tie wait");
    repeat (17) tick();
    pll_locked = 1'b1;
    repeat (2) tick();
    check("tie W19 state", state, S_WAIT);
    tick();
    check("tie W20 state", state, S_STABLE);
    check("tie W20 retry", retry_cnt, 0);

    // Loss counter saturation, then reset while qualifying.
    wait_model(S_RUN, 40, "sat first run");
    for (int i = 0; i < 260; i++) begin
      pll_locked = 1'b0;
      wait_model(S_RESET, 10, "sat loss");
      pll_locked = 1'b1;
      wait_model(S_RUN, 60, "sat relock");
      if (i == 254) check("sat lost at 255", lost_cnt, 255);
    end
    check("sat lost final", lost_cnt, 255);
    pll_locked = 1'b0;
    wait_model(S_RESET, 10, "sat last loss");
    pll_locked = 1'b1;
    wait_model(S_STABLE, 40, "sat stable");
    repeat (2) tick();
    rst = 1'b1;
    tick();
    check("midrst state", state, S_RESET);
    check("midrst pll_rst", pll_rst, 1);
    check("midrst sys_rst", sys_rst, 1);
    check("midrst ready", ready, 0);
    check("midrst lost", lost_cnt, 0);
    rst = 1'b0;

    // Randomized lock activity with occasional resets.
    for (int seg = 0; seg < 200; seg++) begin
      pll_locked = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 29) == 0);
      if (rst) begin
        tick();
        rst = 1'b0;
      end
      repeat ($urandom_range(1, 30)) tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
